// File: rtl/tm1638_bus_arbiter.sv
// TM1638 bus arbiter: grants whole frames from two byte requesters to a
// single serial byte engine, drives the frame strobe and the dio direction,
// and returns read bytes to the requester that owns the frame.
// Optional build macro TM1638_ARB_TIMEOUT_EN: aborts a frame whose owner
// leaves the ISSUE state waiting for a byte for 256 cycles.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | strobe high, arbitrate between pending requesters
// SETUP     | strobe low for one cycle before the first byte
// ISSUE     | wait for the granted byte, hand it to the engine
// WAIT_BUSY | engine has the byte, wait for it to report busy
// WAIT_DONE | engine shifting, wait for busy to drop; return read data
// GAP       | strobe high for the inter-frame gap, then back to IDLE
module tm1638_bus_arbiter #(
  parameter int clk_mhz    = 50,
  parameter int gap_cycles = clk_mhz
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_last,
  input  logic       req0_rd,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_last,
  input  logic       req1_rd,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       eng_latch,
  output logic [7:0] eng_data_in,
  input  logic       eng_busy,
  input  logic [7:0] eng_data_out,
  output logic       sio_stb,
  output logic       sio_rw
);

  // The gap never drops below 1 us, whatever gap_cycles is set to.
  localparam int gap_len = (gap_cycles < clk_mhz) ? clk_mhz : gap_cycles;
  localparam int gw = $clog2(gap_len + 1);
  localparam logic [gw-1:0] gap_load = gw'(gap_len);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    GAP       = 3'd5
  } state_t;

  state_t        state;
  logic          grant;
  logic          prio;
  logic          cur_last;
  logic          cur_rd;
  logic [gw-1:0] gap_cnt;
`ifdef TM1638_ARB_TIMEOUT_EN
  logic [7:0]    to_cnt;
`endif

  logic       sel_valid;
  logic       sel_last;
  logic       sel_rd;
  logic [7:0] sel_data;
  logic       accept;
  logic       pick;
  logic       pick_rd;

  // Granted-requester mux, arbitration pick and the byte handshake. Ready and
  // latch are decoded from state so the byte is taken in the cycle it is seen.
  always_comb begin
    sel_valid   = grant ? req1_valid : req0_valid;
    sel_last    = grant ? req1_last  : req0_last;
    sel_rd      = grant ? req1_rd    : req0_rd;
    sel_data    = grant ? req1_data  : req0_data;
    pick        = (req0_valid & req1_valid) ? prio : req1_valid;
    pick_rd     = pick ? req1_rd : req0_rd;
    accept      = (state == ISSUE) & sel_valid;
    req0_ready  = accept & ~grant;
    req1_ready  = accept & grant;
    eng_latch   = accept;
    eng_data_in = (accept & ~sel_rd) ? sel_data : 8'h00;
  end

  // Frame sequencer with registered strobe, direction and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= 1'b0;
      prio      <= 1'b0;
      cur_last  <= 1'b0;
      cur_rd    <= 1'b0;
      gap_cnt   <= '0;
      sio_stb   <= 1'b1;
      sio_rw    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= 1'b0;
`ifdef TM1638_ARB_TIMEOUT_EN
      to_cnt    <= 8'd0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid | req1_valid) begin
            grant   <= pick;
            prio    <= ~pick;
            sio_stb <= 1'b0;
            sio_rw  <= ~pick_rd;
            state   <= SETUP;
          end
        end
        SETUP: begin
          state <= ISSUE;
`ifdef TM1638_ARB_TIMEOUT_EN
          to_cnt <= 8'd255;
`endif
        end
        ISSUE: begin
          if (sel_valid) begin
            cur_last <= sel_last;
            cur_rd   <= sel_rd;
            sio_rw   <= ~sel_rd;
            state    <= WAIT_BUSY;
          end
`ifdef TM1638_ARB_TIMEOUT_EN
          else if (to_cnt == 8'd0) begin
            sio_stb <= 1'b1;
            sio_rw  <= 1'b1;
            gap_cnt <= gap_load;
            state   <= GAP;
          end else begin
            to_cnt <= to_cnt - 8'd1;
          end
`endif
        end
        WAIT_BUSY: begin
          if (eng_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!eng_busy) begin
            if (cur_rd) begin
              rsp_valid <= 1'b1;
              rsp_data  <= eng_data_out;
              rsp_id    <= grant;
            end
            if (cur_last) begin
              sio_stb <= 1'b1;
              sio_rw  <= 1'b1;
              gap_cnt <= gap_load;
              state   <= GAP;
            end else begin
              state <= ISSUE;
`ifdef TM1638_ARB_TIMEOUT_EN
              to_cnt <= 8'd255;
`endif
            end
          end
        end
        GAP: begin
          // Saturating down-count; terminal count 1 gives gap_len GAP cycles.
          if (gap_cnt <= gw'(1)) state <= IDLE;
          else gap_cnt <= gap_cnt - gw'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_bus_arbiter.sv
// Directed bench for tm1638_bus_arbiter: queue-fed requesters, a simple
// serial-engine model and negedge monitors feed immediate-assertion checks.
module tb_tm1638_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req0_rd = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0, req1_last = 1'b0, req1_rd = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       eng_latch;
  logic [7:0] eng_data_in;
  logic       eng_busy = 1'b0;
  logic [7:0] eng_data_out = 8'h00;
  logic       sio_stb;
  logic       sio_rw;

  always #5 clk = ~clk;

  tm1638_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_last(req0_last), .req0_rd(req0_rd),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_last(req1_last), .req1_rd(req1_rd),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .eng_latch(eng_latch), .eng_data_in(eng_data_in),
    .eng_busy(eng_busy), .eng_data_out(eng_data_out),
    .sio_stb(sio_stb), .sio_rw(sio_rw)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       rd;
  } item_t;

  item_t      q0[$], q1[$];
  logic [7:0] eng_rd_q[$];
  logic [7:0] lat_dat[$];
  logic       lat_id[$];
  logic [7:0] rsp_dat[$];
  logic       rsp_idq[$];
  logic       rw_log[$];
  int         gap_log[$];

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, lat_cyc = 0, fall_cyc = 0, rise_cyc = 0, busy_fall_cyc = 0, viol = 0;
  int   eng_cnt = 0;
  logic stb_q = 1'b1, busy_q = 1'b0;
  logic hs0 = 1'b0, hs1 = 1'b0, lat_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d, input logic last, input logic rd);
    item_t it;
    it.data = d;
    it.last = last;
    it.rd   = rd;
    if (id == 0) q0.push_back(it);
    else q1.push_back(it);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_lat(input int n);
    for (int i = 0; i < 3000 && lat_dat.size() < n; i++) step(1);
    check("lat_count", lat_dat.size(), n);
  endtask

  task automatic wait_rise();
    for (int i = 0; i < 3000 && sio_stb !== 1'b1; i++) step(1);
    check("stb_rise", sio_stb, 1'b1);
  endtask

  task automatic clear_logs();
    lat_dat.delete(); lat_id.delete(); rsp_dat.delete(); rsp_idq.delete();
    rw_log.delete(); gap_log.delete(); eng_rd_q.delete();
    rise_cyc = 0; fall_cyc = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    clear_logs();
  endtask

  // Mid-cycle monitor: handshakes, latched bytes, responses, strobe edges.
  always @(negedge clk) begin
    cyc++;
    hs0 = req0_valid & req0_ready;
    hs1 = req1_valid & req1_ready;
    lat_seen = eng_latch;
    if (eng_latch) begin
      lat_id.push_back(req1_ready);
      lat_dat.push_back(eng_data_in);
      lat_cyc = cyc;
    end
    if (req0_ready && req1_ready) viol++;
    if ((req0_ready | req1_ready) !== eng_latch) viol++;
    if (rsp_valid) begin
      rsp_dat.push_back(rsp_data);
      rsp_idq.push_back(rsp_id);
    end
    if (eng_busy && !busy_q) rw_log.push_back(sio_rw);
    if (!eng_busy && busy_q) busy_fall_cyc = cyc;
    if (!sio_stb && stb_q) begin
      fall_cyc = cyc;
      if (rise_cyc > 0) gap_log.push_back(cyc - rise_cyc);
    end
    if (sio_stb && !stb_q) rise_cyc = cyc;
    busy_q = eng_busy;
    stb_q  = sio_stb;
  end

  // Requesters pop on handshake; the engine goes busy 2 cycles after a latch for 8 cycles.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      eng_cnt  = 0;
      eng_busy = 1'b0;
      lat_seen = 1'b0;
    end else begin
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      if (lat_seen) begin
        eng_cnt = 10;
        if (eng_rd_q.size() > 0) eng_data_out = eng_rd_q.pop_front();
      end else if (eng_cnt > 0) begin
        eng_cnt--;
      end
      eng_busy = (eng_cnt > 0) && (eng_cnt <= 8);
    end
    hs0 = 1'b0;
    hs1 = 1'b0;
    lat_seen = 1'b0;
    req0_valid = q0.size() > 0;
    if (q0.size() > 0) begin
      req0_data = q0[0].data; req0_last = q0[0].last; req0_rd = q0[0].rd;
    end
    req1_valid = q1.size() > 0;
    if (q1.size() > 0) begin
      req1_data = q1[0].data; req1_last = q1[0].last; req1_rd = q1[0].rd;
    end
  end

  initial begin
    // Reset values while rst_n is low.
    step(1);
    check("rst_stb", sio_stb, 1'b1);
    check("rst_rw", sio_rw, 1'b1);
    check("rst_latch", eng_latch, 1'b0);
    check("rst_eng_data", eng_data_in, 8'h00);
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_id", rsp_id, 1'b0);
    do_reset();

    // Single-byte frame from req0.
    push(0, 8'h40, 1'b1, 1'b0);
    wait_lat(1);
    check("t1_stb_lead", lat_cyc, fall_cyc + 1);
    check("t1_data", lat_dat[0], 8'h40);
    check("t1_id", lat_id[0], 1'b0);
    wait_rise();
    check("t1_rise_after_busy", rise_cyc, busy_fall_cyc + 1);
    step(60);
    check("t1_stb_held", sio_stb, 1'b1);
    check("t1_no_extra", lat_dat.size(), 1);

    // Simultaneous 3-byte frames; req0 first, no interleave, 51-cycle high run.
    do_reset();
    push(0, 8'h10, 1'b0, 1'b0); push(0, 8'h11, 1'b0, 1'b0); push(0, 8'h12, 1'b1, 1'b0);
    push(1, 8'h20, 1'b0, 1'b0); push(1, 8'h21, 1'b0, 1'b0); push(1, 8'h22, 1'b1, 1'b0);
    wait_lat(6);
    for (int i = 0; i < 6; i++) begin
      check("t2_id", lat_id[i], (i < 3) ? 1'b0 : 1'b1);
      check("t2_data", lat_dat[i], (i < 3) ? 8'h10 + 8'(i) : 8'h20 + 8'(i - 3));
    end
    check("t2_gap", gap_log[0], 51);
    wait_rise();

    // req1 write then two reads; engine returns A5 then 3C.
    do_reset();
    eng_rd_q.push_back(8'h00); eng_rd_q.push_back(8'hA5); eng_rd_q.push_back(8'h3C);
    push(1, 8'h42, 1'b0, 1'b0); push(1, 8'h77, 1'b0, 1'b1); push(1, 8'h77, 1'b1, 1'b1);
    wait_lat(3);
    wait_rise();
    check("t3_rsp_count", rsp_dat.size(), 2);
    check("t3_rsp0", rsp_dat[0], 8'hA5);
    check("t3_rsp1", rsp_dat[1], 8'h3C);
    check("t3_rsp_id0", rsp_idq[0], 1'b1);
    check("t3_rsp_id1", rsp_idq[1], 1'b1);
    check("t3_lat0", lat_dat[0], 8'h42);
    check("t3_lat1", lat_dat[1], 8'h00);
    check("t3_lat2", lat_dat[2], 8'h00);
    check("t3_rw0", rw_log[0], 1'b1);
    check("t3_rw1", rw_log[1], 1'b0);
    check("t3_rw2", rw_log[2], 1'b0);

    // Reset during WAIT_DONE of byte 2 (a read) of a req0 frame.
    do_reset();
    eng_rd_q.push_back(8'h00); eng_rd_q.push_back(8'hB1); eng_rd_q.push_back(8'hB2);
    push(0, 8'h50, 1'b0, 1'b0); push(0, 8'h77, 1'b0, 1'b1); push(0, 8'h77, 1'b1, 1'b1);
    wait_lat(2);
    for (int i = 0; i < 100 && eng_busy !== 1'b1; i++) step(1);
    check("t4_busy_seen", eng_busy, 1'b1);
    step(2);
    check("t4_stb_low_before", sio_stb, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t4_stb_async", sio_stb, 1'b1);
    check("t4_rsp_valid", rsp_valid, 1'b0);
    step(3);
    rst_n = 1'b1;
    lat_dat.delete(); lat_id.delete(); eng_rd_q.delete();
    push(0, 8'h60, 1'b1, 1'b0);
    push(1, 8'h61, 1'b1, 1'b0);
    wait_lat(2);
    check("t4_first_id", lat_id[0], 1'b0);
    check("t4_first_data", lat_dat[0], 8'h60);
    check("t4_second_id", lat_id[1], 1'b1);
    wait_rise();
    check("t4_no_rsp", rsp_dat.size(), 0);

    // req0 stalls mid-frame for 300 cycles with req1 pending.
    do_reset();
    push(0, 8'h70, 1'b0, 1'b0);
    wait_lat(1);
    push(1, 8'h80, 1'b1, 1'b0);
    step(300);
    check("t5_latches", lat_dat.size(), 1);
`ifdef TM1638_ARB_TIMEOUT_EN
    check("t5_stb_aborted", sio_stb, 1'b1);
    wait_lat(2);
    check("t5_next_id", lat_id[1], 1'b1);
    check("t5_next_data", lat_dat[1], 8'h80);
`else
    check("t5_stb_held_low", sio_stb, 1'b0);
    push(0, 8'h71, 1'b1, 1'b0);
    wait_lat(3);
    check("t5_resume_data", lat_dat[1], 8'h71);
    check("t5_resume_id", lat_id[1], 1'b0);
    check("t5_next_id", lat_id[2], 1'b1);
    check("t5_next_data", lat_dat[2], 8'h80);
`endif
    wait_rise();

    check("ready_exclusive", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tm1638_bus_arbiter.md
TM1638_BUS_ARBITER -- requirements
Module: tm1638_bus_arbiter

Interface
REQ-001 The block SHALL have parameter clk_mhz, default 50, meaning system clock frequency in MHz.
REQ-002 The block SHALL have parameter gap_cycles, default clk_mhz, meaning the strobe-high gap length in clocks (at least 1 us).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports reqN_valid, reqN_last and reqN_rd (N=0,1), each input, 1 bit: byte offered, final byte of frame, and byte is a read slot (dio released).
REQ-006 The block SHALL have port reqN_data (N=0,1), input, 8 bits: byte to send; ignored for the transfer when reqN_rd=1.
REQ-007 The block SHALL have port reqN_ready (N=0,1), output, 1 bit: byte accepted this cycle.
REQ-008 The block SHALL have ports rsp_valid (output, 1 bit), rsp_data (output, 8 bits) and rsp_id (output, 1 bit): read byte returned and its requester.
REQ-009 The block SHALL have ports eng_latch (output, 1 bit), eng_data_in (output, 8 bits), eng_busy (input, 1 bit) and eng_data_out (input, 8 bits): handshake with the serial byte engine.
REQ-010 The block SHALL have ports sio_stb (output, 1 bit, active-low frame strobe) and sio_rw (output, 1 bit, 1 = block drives dio).

Function
REQ-011 States SHALL be IDLE, SETUP, ISSUE, WAIT_BUSY, WAIT_DONE and GAP.
- IDLE: sio_stb=1. Any valid request → SETUP, with the grant latched for the whole frame.
REQ-012 Arbitration SHALL be round-robin per frame.
- Simultaneous valid requests: grant goes to the requester not granted last.
- First arbitration after reset favours req0.
REQ-013 SETUP SHALL last exactly 1 cycle, with sio_stb=0 and sio_rw=~rd of the granted byte; next state is ISSUE.
REQ-014 ISSUE SHALL wait for the granted reqN_valid, then do the following in one cycle:
- assert eng_latch=1 and reqN_ready=1;
- drive eng_data_in=reqN_data (0x00 if rd);
- set sio_rw=~rd;
- store last and rd;
- go to WAIT_BUSY.
REQ-015 eng_latch SHALL be a single-cycle pulse, and the non-granted ready SHALL stay 0 for the whole frame.
REQ-016 WAIT_BUSY SHALL wait for eng_busy=1, then go to WAIT_DONE; WAIT_DONE SHALL wait for eng_busy=0.
REQ-017 On leaving WAIT_DONE for a read byte, the block SHALL pulse rsp_valid=1 for exactly 1 cycle, with rsp_data=eng_data_out and rsp_id=granted index.
REQ-018 On leaving WAIT_DONE, the next state SHALL be GAP if the stored last=1, else ISSUE, with sio_stb held 0 throughout the frame.
REQ-019 GAP SHALL set sio_stb=1 and sio_rw=1 and count gap_cycles clocks before returning to IDLE; requests arriving during GAP wait.
REQ-020 A single-byte frame (last=1 on the first byte) SHALL be legal.
REQ-021 The gap counter SHALL be $clog2(gap_cycles+1) bits wide and SHALL NOT wrap.

Reset
REQ-022 While rst_n=0, outputs SHALL be:
- sio_stb=1, sio_rw=1, eng_latch=0, eng_data_in=0x00;
- reqN_ready=0, rsp_valid=0, rsp_data=0x00, rsp_id=0;
- state IDLE, round-robin pointer favouring req0.
REQ-023 A reset asserted mid-frame SHALL raise sio_stb immediately (asynchronously) and discard the frame without any rsp pulse.

Configuration
REQ-024 With TM1638_ARB_TIMEOUT_EN defined, an ISSUE state waiting more than 255 cycles for valid SHALL abort the frame: go to GAP with no ready or rsp pulse, and the round-robin pointer advances.
REQ-025 Without TM1638_ARB_TIMEOUT_EN, ISSUE SHALL wait indefinitely and no timeout counter SHALL exist.

Verification
REQ-026 req0 sends a frame {0x40 last} → sio_stb falls 1 cycle before eng_latch, eng_data_in=0x40, sio_stb rises after busy falls, then stays high ≥50 cycles.
REQ-027 req0 and req1 valid in the same cycle, both sending 3-byte frames → req0 frame is completed first, then req1, with no interleaved bytes and a 50-cycle gap between them.
REQ-028 req1 sends frame {0x42, rd, rd last} with the engine returning 0xA5 then 0x3C → two rsp_valid pulses with rsp_data 0xA5 then 0x3C and rsp_id=1; sio_rw=0 during the rd bytes.
REQ-029 rst_n pulled low during WAIT_DONE of byte 2 → sio_stb=1 within the same cycle, no rsp_valid pulse, and req0 wins the next arbitration.
REQ-030 With TM1638_ARB_TIMEOUT_EN, req0 drops valid mid-frame for 300 cycles → frame aborted at cycle 256, sio_stb=1, and a pending req1 is granted after the gap; without the macro, sio_stb stays 0.
